// File: rtl/avalon_mem_slave.sv
// avalon_mem_slave: Avalon-MM slave memory answering CPU fetches, loads and stores.
// Two windows decoded on the word index address[31:2]:
//   - ROM_BASE: read-only instruction ROM, all zero at time 0
//   - RAM_BASE: byte-writable data RAM
// Writes to the ROM window, writes outside both windows and read+write in one
// accept set a sticky fault flag. waitrequest comes from a wait-state counter.
// Build option AVALON_MEM_RANDOM_WAIT_EN: the wait count of each request is drawn
// from an 8-bit LFSR (0..WAIT_STATES) instead of being fixed at WAIT_STATES.
module avalon_mem_slave #(
    parameter logic [31:0] ROM_BASE      = 32'hBFC0_0000,
    parameter int          ROM_AW        = 10,
    parameter logic [31:0] RAM_BASE      = 32'h0000_0000,
    parameter int          RAM_AW        = 12,
    parameter int          WAIT_STATES   = 0,
    parameter string       ROM_INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    output logic        waitrequest,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        fault
);
    localparam int         ROM_DEPTH = 1 << ROM_AW;
    localparam int         RAM_DEPTH = 1 << RAM_AW;
    localparam logic [7:0] WS_MAX    = 8'(WAIT_STATES);

    logic [31:0]       rom [ROM_DEPTH];
    logic [31:0]       ram [RAM_DEPTH];

    logic [7:0]        cnt;
    logic [7:0]        wait_target;
    logic              req;
    logic              accept;
    logic              ram_we;
    logic [29:0]       rom_off;
    logic [29:0]       ram_off;
    logic              rom_hit;
    logic              ram_hit;
    logic [ROM_AW-1:0] rom_idx;
    logic [RAM_AW-1:0] ram_idx;
    logic [31:0]       rd_word;
    logic [1:0]        unused_addr_lsb;

    // Byte lanes inside a word are selected by byteenable, not by the address
    assign unused_addr_lsb = address[1:0];

    // ROM image: all zero at time 0
    initial begin
        for (int i = 0; i < ROM_DEPTH; i++)
            rom[i] = 32'h0;
    end

    // Window decode on the word index; ROM wins if the windows were ever overlapped
    assign rom_off = address[31:2] - ROM_BASE[31:2];
    assign ram_off = address[31:2] - RAM_BASE[31:2];
    assign rom_hit = (rom_off >> ROM_AW) == 30'd0;
    assign ram_hit = ((ram_off >> RAM_AW) == 30'd0) && !rom_hit;
    assign rom_idx = rom_off[ROM_AW-1:0];
    assign ram_idx = ram_off[RAM_AW-1:0];

    assign req         = read | write;
    assign waitrequest = req && (cnt != wait_target);
    assign accept      = req && !waitrequest;
    assign ram_we      = accept && write && ram_hit;

    // Word seen by a read; addresses outside both windows read as zero
    always_comb begin
        rd_word = 32'h0;
        if (rom_hit)
            rd_word = rom[rom_idx];
        else if (ram_hit)
            rd_word = ram[ram_idx];
    end

    // Wait-state counter: counts stall cycles, restarts on accept or dropped request
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= 8'd0;
        else if (req && waitrequest)
            cnt <= cnt + 8'd1;
        else
            cnt <= 8'd0;
    end

`ifdef AVALON_MEM_RANDOM_WAIT_EN
    logic [7:0] lfsr;
    logic       lfsr_fb;
    logic [8:0] lfsr_mod;
    logic       unused_mod_msb;

    assign lfsr_fb        = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign lfsr_mod       = {1'b0, lfsr} % (9'(WAIT_STATES) + 9'd1);
    assign unused_mod_msb = lfsr_mod[8];

    // LFSR steps once per accept; its value sets the wait count of the next request
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr        <= 8'hA5;
            wait_target <= WS_MAX;
        end else if (accept) begin
            lfsr        <= {lfsr[6:0], lfsr_fb};
            wait_target <= lfsr_mod[7:0];
        end
    end
`else
    assign wait_target = WS_MAX;
`endif

    // Accept side effects: read data capture and the sticky fault flag
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= 32'h0;
            fault    <= 1'b0;
        end else if (accept) begin
            if (read && !write)
                readdata <= rd_word;
            if ((write && !ram_hit) || (read && write))
                fault <= 1'b1;
        end
    end

    // RAM store with per-lane enables; contents survive reset
    always_ff @(posedge clk) begin
        if (!reset && ram_we) begin
            for (int i = 0; i < 4; i++)
                if (byteenable[i])
                    ram[ram_idx][8*i +: 8] <= writedata[8*i +: 8];
        end
    end

endmodule

// File: tb/tb_avalon_mem_slave.sv
// Bench for avalon_mem_slave: four instances with WAIT_STATES 0, 3, 2 and 7 are
// driven with directed and random traffic; a word-level model (windows, byte
// lanes, stall count per request) is compared against every instance each cycle.
module tb_avalon_mem_slave;
    localparam int          NI    = 4;
    localparam int unsigned ROM_W = 32'h2FF0_0000;

    function automatic int ws_of(input int k);
        case (k)
            0:       return 0;
            1:       return 3;
            2:       return 2;
            default: return 7;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address     [NI];
    logic        read        [NI];
    logic        write       [NI];
    logic        waitrequest [NI];
    logic [31:0] writedata   [NI];
    logic [3:0]  byteenable  [NI];
    logic [31:0] readdata    [NI];
    logic        fault       [NI];

    always #5 clk = ~clk;

    generate
        for (genvar i = 0; i < NI; i++) begin : g_dut
            avalon_mem_slave #(.WAIT_STATES(ws_of(i))) u_dut (
                .clk         (clk),
                .reset       (reset),
                .address     (address[i]),
                .read        (read[i]),
                .write       (write[i]),
                .waitrequest (waitrequest[i]),
                .writedata   (writedata[i]),
                .byteenable  (byteenable[i]),
                .readdata    (readdata[i]),
                .fault       (fault[i])
            );
        end
    endgenerate

    int          pend     [NI];
    logic [31:0] m_rd     [NI];
    logic        m_fault  [NI];
    bit          rd_known [NI];
    logic        wr_seen  [NI];
    logic [31:0] ram_m [int];
    logic [31:0] rom_m [int];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          started  = 1'b0;
    bit          m_acc;
    logic        exp_wr;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %h, expected %h (t=%0t)", name, k, act, exp, $time);
        end
    endtask

    // 0 = no window, 1 = ROM, 2 = RAM
    function automatic int win(input logic [31:0] a);
        int unsigned w;
        w = a >> 2;
        if (w >= ROM_W && w < ROM_W + 1024)
            return 1;
        if (w < 4096)
            return 2;
        return 0;
    endfunction

    function automatic int key_of(input int k, input logic [31:0] a);
        int unsigned w;
        w = a >> 2;
        if (win(a) == 1)
            return k * 1024 + int'(w - ROM_W);
        return k * 4096 + int'(w);
    endfunction

    task automatic m_apply(input int k);
        int          w;
        int          key;
        logic [31:0] cur;
        w   = win(address[k]);
        key = key_of(k, address[k]);
        if (write[k]) begin
            if (w == 2) begin
                cur = ram_m.exists(key) ? ram_m[key] : 32'h0;
                for (int i = 0; i < 4; i++)
                    if (byteenable[k][i])
                        cur[8*i +: 8] = writedata[k][8*i +: 8];
                ram_m[key] = cur;
            end else begin
                m_fault[k] = 1'b1;
            end
        end
        if (read[k] && write[k]) begin
            m_fault[k] = 1'b1;
        end else if (read[k]) begin
            rd_known[k] = 1'b1;
            if (w == 1)
                m_rd[k] = rom_m.exists(key) ? rom_m[key] : 32'h0;
            else if (w == 2) begin
                if (ram_m.exists(key))
                    m_rd[k] = ram_m[key];
                else
                    rd_known[k] = 1'b0;
            end else
                m_rd[k] = 32'h0;
        end
    endtask

    // Reference model: advances at each clock edge from the inputs held across it
    always @(posedge clk) begin
        if (reset)
            started = 1'b1;
        for (int k = 0; k < NI; k++) begin
            if (reset) begin
                pend[k]     = 0;
                m_rd[k]     = 32'h0;
                m_fault[k]  = 1'b0;
                rd_known[k] = 1'b1;
            end else if (read[k] || write[k]) begin
`ifdef AVALON_MEM_RANDOM_WAIT_EN
                m_acc = !wr_seen[k];
`else
                m_acc = (pend[k] == ws_of(k));
`endif
                if (!m_acc) begin
                    pend[k]++;
                end else begin
                    pend[k] = 0;
                    m_apply(k);
                end
            end else begin
                pend[k] = 0;
            end
        end
    end

    // Compare every instance against the model away from the active edge
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            wr_seen[k] = waitrequest[k];
            if (started) begin
                exp_wr = (read[k] || write[k]) && (pend[k] != ws_of(k));
`ifdef AVALON_MEM_RANDOM_WAIT_EN
                if (!(read[k] || write[k]) || pend[k] == ws_of(k))
                    chk("waitrequest", k, 32'(waitrequest[k]), 32'(exp_wr));
`else
                chk("waitrequest", k, 32'(waitrequest[k]), 32'(exp_wr));
`endif
                if (rd_known[k])
                    chk("readdata", k, readdata[k], m_rd[k]);
                chk("fault", k, 32'(fault[k]), 32'(m_fault[k]));
            end
        end
    end

    // One bus transaction, entered and left just after a rising edge
    task automatic bus_req(input int k, input logic r, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] be, output int stalls);
        bit done;
        done          = 1'b0;
        stalls        = 0;
        address[k]    = a;
        read[k]       = r;
        write[k]      = w;
        writedata[k]  = d;
        byteenable[k] = be;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (!waitrequest[k]) begin
                done = 1'b1;
                @(posedge clk);
                #1;
            end else begin
                @(posedge clk);
                #1;
                stalls++;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout inst%0d: got no accept, expected one within 300 cycles", k);
        end
        read[k]  = 1'b0;
        write[k] = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: got no end of test, expected one before 1 ms");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int          s;
        int          op;
        int          rg;
        int          smin;
        int          smax;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        logic [3:0]  seq;

        reset = 1'b1;
        for (int k = 0; k < NI; k++) begin
            address[k]    = 32'h0;
            read[k]       = 1'b0;
            write[k]      = 1'b0;
            writedata[k]  = 32'h0;
            byteenable[k] = 4'h0;
        end
        #1;
        g_dut[0].u_dut.rom[0] = 32'h2402_0005;
        g_dut[0].u_dut.rom[1] = 32'hDEAD_BEEF;
        g_dut[1].u_dut.rom[0] = 32'h2402_0005;
        g_dut[1].u_dut.rom[1] = 32'hDEAD_BEEF;
        g_dut[2].u_dut.rom[0] = 32'h2402_0005;
        g_dut[2].u_dut.rom[1] = 32'hDEAD_BEEF;
        g_dut[3].u_dut.rom[0] = 32'h2402_0005;
        g_dut[3].u_dut.rom[1] = 32'hDEAD_BEEF;
        for (int k = 0; k < NI; k++) begin
            rom_m[k * 1024 + 0] = 32'h2402_0005;
            rom_m[k * 1024 + 1] = 32'hDEAD_BEEF;
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        @(negedge clk);
        chk("reset_readdata", 0, readdata[0], 32'h0);
        chk("reset_fault", 0, 32'(fault[0]), 32'd0);
        @(posedge clk);
        #1;

        // WAIT_STATES=3: read held high gives 1,1,1,0 then data
        address[1] = 32'hBFC0_0000;
        read[1]    = 1'b1;
        seq        = 4'h0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            seq[3-c] = waitrequest[1];
            @(posedge clk);
            #1;
        end
        read[1] = 1'b0;
        chk("ws3_wait_seq", 1, 32'(seq), 32'(4'b1110));
        @(negedge clk);
        chk("ws3_data", 1, readdata[1], 32'h2402_0005);
        @(posedge clk);
        #1;

        // WAIT_STATES=2: drop after one stall, re-issue, expect two fresh stalls
        address[2] = 32'hBFC0_0000;
        read[2]    = 1'b1;
        @(negedge clk);
        chk("ws2_first_stall", 2, 32'(waitrequest[2]), 32'd1);
        @(posedge clk);
        #1;
        read[2] = 1'b0;
        cycles(1);
        bus_req(2, 1'b1, 1'b0, 32'hBFC0_0000, 32'h0, 4'h0, s);
        chk("ws2_reissue_stalls", 2, 32'(s), 32'd2);
        @(negedge clk);
        chk("ws2_data", 2, readdata[2], 32'h2402_0005);
        @(posedge clk);
        #1;

        // WAIT_STATES=0: accepted in the request cycle, data the next cycle
        address[0] = 32'hBFC0_0000;
        read[0]    = 1'b1;
        @(negedge clk);
        chk("ws0_no_wait", 0, 32'(waitrequest[0]), 32'd0);
        @(posedge clk);
        #1;
        read[0] = 1'b0;
        @(negedge clk);
        chk("ws0_data", 0, readdata[0], 32'h2402_0005);
        @(posedge clk);
        #1;

        // Byte-lane merge in RAM
        bus_req(0, 1'b0, 1'b1, 32'h0000_0010, 32'h1122_3344, 4'b1111, s);
        bus_req(0, 1'b0, 1'b1, 32'h0000_0010, 32'hAABB_CCDD, 4'b0101, s);
        bus_req(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, s);
        @(negedge clk);
        chk("byte_merge", 0, readdata[0], 32'h11BB_33DD);
        @(posedge clk);
        #1;

        // Preload RAM words 0..31 of every instance
        for (int k = 0; k < NI; k++)
            for (int w = 0; w < 32; w++)
                bus_req(k, 1'b0, 1'b1, 32'(w * 4), $urandom, 4'hF, s);

        // Random mixed traffic across all windows
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 80; n++) begin
                op = int'($urandom_range(0, 9));
                rg = int'($urandom_range(0, 5));
                case (rg)
                    4:       a = 32'hBFC0_0000 + ($urandom_range(0, 3) << 2);
                    5:       a = 32'h8000_0000 + ($urandom_range(0, 255) << 2);
                    default: a = $urandom_range(0, 31) << 2;
                endcase
                a[1:0] = 2'($urandom_range(0, 3));
                d      = $urandom;
                be     = 4'($urandom_range(0, 15));
                if (op == 9)
                    cycles(1);
                else
                    bus_req(k, (op < 5) || (op == 8), op >= 5, a, d, be, s);
            end
        end

        // Reset during a stalled write: the write must not land
        address[1]    = 32'h0000_0014;
        writedata[1]  = 32'hCAFE_F00D;
        byteenable[1] = 4'hF;
        write[1]      = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        #1;
        reset    = 1'b1;
        write[1] = 1'b0;
        cycles(2);
        reset = 1'b0;
        bus_req(1, 1'b1, 1'b0, 32'h0000_0014, 32'h0, 4'h0, s);

        // Fault behaviour
        @(negedge clk);
        chk("fault_after_reset", 0, 32'(fault[0]), 32'd0);
        @(posedge clk);
        #1;
        bus_req(0, 1'b0, 1'b1, 32'hBFC0_0004, 32'h1234_5678, 4'hF, s);
        @(negedge clk);
        chk("rom_write_fault", 0, 32'(fault[0]), 32'd1);
        @(posedge clk);
        #1;
        bus_req(0, 1'b1, 1'b0, 32'hBFC0_0004, 32'h0, 4'h0, s);
        @(negedge clk);
        chk("rom_unchanged", 0, readdata[0], 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        bus_req(0, 1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'h0, s);
        @(negedge clk);
        chk("unmapped_read", 0, readdata[0], 32'h0);
        chk("fault_sticky", 0, 32'(fault[0]), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        @(negedge clk);
        chk("fault_cleared", 0, 32'(fault[0]), 32'd0);
        @(posedge clk);
        #1;

        // 100 reads on the WAIT_STATES=7 instance
        smin = 99;
        smax = -1;
        for (int n = 0; n < 100; n++) begin
            if ($urandom_range(0, 3) == 0)
                a = 32'hBFC0_0000 + ($urandom_range(0, 1) << 2);
            else
                a = $urandom_range(0, 31) << 2;
            bus_req(3, 1'b1, 1'b0, a, 32'h0, 4'h0, s);
            chk("stall_bound", 3, 32'(s <= 7), 32'd1);
`ifndef AVALON_MEM_RANDOM_WAIT_EN
            chk("stall_fixed", 3, 32'(s), 32'd7);
`endif
            if (s < smin) smin = s;
            if (s > smax) smax = s;
        end
`ifdef AVALON_MEM_RANDOM_WAIT_EN
        chk("stall_min_seen", 3, 32'(smin), 32'd0);
        chk("stall_max_seen", 3, 32'(smax), 32'd7);
`endif
        cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
